// File: rtl/wb_ram_bist_pkg.sv
// rtl/wb_ram_bist_pkg.sv - shared types, constants and pattern function for the RAM BIST master
//
// Purpose : FSM state enum, pass encoding, byte-select constant, timeout
//           sentinel and the P(seed, index, invert) pattern function.
// Ports   : none (package).
package wb_ram_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_ACK,
    GAP,
    DONE
  } state_e;

  // Bit 0 set = read/compare pass, bit 1 set = inverted pattern.
  typedef enum logic [1:0] {
    PASS_WR     = 2'd0,
    PASS_RD     = 2'd1,
    PASS_WR_INV = 2'd2,
    PASS_RD_INV = 2'd3
  } pass_e;

  localparam logic [3:0]  SEL_ALL      = 4'hF;
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_DEAD;

  function automatic logic [31:0] pattern(input logic [31:0] seed,
                                          input logic [15:0] idx,
                                          input logic        invert);
    logic [31:0] p;
    p = seed ^ {idx, ~idx};
    return invert ? ~p : p;
  endfunction

endpackage

// File: rtl/wb_ram_bist_pattern.sv
// rtl/wb_ram_bist_pattern.sv - combinational write/expected data generator
//
// Purpose : maps (word index, pass) to the bus data word and write enable.
// Ports   : index_i  word index
//           pass_i   2-bit pass number
//           data_o   pattern word for this pass (write data or expected read)
//           we_o     1 on write passes
module wb_ram_bist_pattern
  import wb_ram_bist_pkg::*;
#(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] SEED       = 32'h5A5A_C3C3
) (
  input  logic [ADDR_WIDTH-1:0] index_i,
  input  logic [1:0]            pass_i,
  output logic [31:0]           data_o,
  output logic                  we_o
);

  logic [15:0] idx16;

  assign idx16  = 16'(index_i);
  assign data_o = pattern(SEED, idx16, pass_i[1]);
  assign we_o   = ~pass_i[0];

endmodule

// File: rtl/wb_ram_bist.sv
// rtl/wb_ram_bist.sv - Wishbone classic master running a two-pattern RAM self-test
//
// Purpose : on start_i, writes P(i) to every word, reads back and compares,
//           then repeats with ~P(i). Stops at the first mismatch.
// Ports   : wb_clk_i, wb_rst_ni           clock, async active-low reset
//           start_i                       one-cycle start request
//           busy_o, done_o, pass_o, fail_o status (pass/fail valid with done_o)
//           fail_addr_o, fail_data_o      first failing index and read data
//           wbm_*                         Wishbone classic master port
// Option  : define WB_RAM_BIST_TIMEOUT_EN to enable the ack watchdog
//           (TIMEOUT_CYCLES cycles without ack reports a failure).
module wb_ram_bist
  import wb_ram_bist_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
  parameter int          ADDR_WIDTH     = 8,
  parameter logic [31:0] SEED           = 32'h5A5A_C3C3,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  fail_o,
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  output logic [31:0]           fail_data_o,
  output logic                  wbm_cyc_o,
  output logic                  wbm_stb_o,
  output logic                  wbm_we_o,
  output logic [3:0]            wbm_sel_o,
  output logic [31:0]           wbm_adr_o,
  output logic [31:0]           wbm_dat_o,
  input  logic [31:0]           wbm_dat_i,
  input  logic                  wbm_ack_i
);

  if (ADDR_WIDTH < 1 || ADDR_WIDTH > 16 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("wb_ram_bist: ADDR_WIDTH must be 1..16 and TIMEOUT_CYCLES at least 2");
  end

  state_e                state_q, state_d;
  pass_e                 pass_q, pass_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  ok_q, ok_d;
  logic                  fail_q, fail_d;
  logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [31:0]           fail_data_q, fail_data_d;

  logic                  cyc_q, stb_q, we_q;
  logic [3:0]            sel_q;
  logic [31:0]           adr_q, dat_q;

  // launch: load bus registers for the next word; drop: end the cycle.
  logic                  launch;
  logic                  drop;
  logic [31:0]           nxt_data;
  logic                  nxt_we;

  // The pattern is generated for the next (index, pass) so the bus registers
  // are valid in the very first REQ cycle.
  wb_ram_bist_pattern #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .SEED       (SEED)
  ) u_pattern (
    .index_i (idx_d),
    .pass_i  (pass_d),
    .data_o  (nxt_data),
    .we_o    (nxt_we)
  );

`ifdef WB_RAM_BIST_TIMEOUT_EN
  localparam int                CNT_W        = $clog2(TIMEOUT_CYCLES);
  // The REQ cycle already counts as one cycle without ack.
  localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);
  logic [CNT_W-1:0]             cnt_q, cnt_d;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end
`endif

  always_comb begin
    state_d     = state_q;
    pass_d      = pass_q;
    idx_d       = idx_q;
    busy_d      = busy_q;
    done_d      = done_q;
    ok_d        = ok_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    launch      = 1'b0;
    drop        = 1'b0;
`ifdef WB_RAM_BIST_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d     = REQ;
          pass_d      = PASS_WR;
          idx_d       = '0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          ok_d        = 1'b0;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          fail_data_d = '0;
          launch      = 1'b1;
        end
      end

      REQ: begin
        state_d = WAIT_ACK;
`ifdef WB_RAM_BIST_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end

      WAIT_ACK: begin
        if (wbm_ack_i) begin
          drop = 1'b1;
          // wbm_dat_o carries the pass pattern on reads too, so it is the
          // expected word for the compare.
          if (pass_q[0] && (wbm_dat_i != dat_q)) begin
            state_d     = DONE;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            fail_d      = 1'b1;
            fail_addr_d = idx_q;
            fail_data_d = wbm_dat_i;
          end else begin
            state_d = GAP;
          end
        end
`ifdef WB_RAM_BIST_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_LAST) begin
          drop        = 1'b1;
          state_d     = DONE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          fail_d      = 1'b1;
          fail_addr_d = idx_q;
          fail_data_d = TIMEOUT_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      GAP: begin
        // Acks arriving here (stb low) are deliberately not looked at.
        if (idx_q == {ADDR_WIDTH{1'b1}}) begin
          idx_d = '0;
          if (pass_q == PASS_RD_INV) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            ok_d    = 1'b1;
          end else begin
            pass_d  = pass_e'(pass_q + 2'd1);
            state_d = REQ;
            launch  = 1'b1;
          end
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = REQ;
          launch  = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= IDLE;
      pass_q      <= PASS_WR;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ok_q        <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else begin
      state_q     <= state_d;
      pass_q      <= pass_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ok_q        <= ok_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
    end
  end

  // Bus outputs are plain registers: stable for the whole of WAIT_ACK and
  // cleared asynchronously by reset.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      cyc_q <= 1'b0;
      stb_q <= 1'b0;
      we_q  <= 1'b0;
      sel_q <= 4'h0;
      adr_q <= '0;
      dat_q <= '0;
    end else if (launch) begin
      cyc_q <= 1'b1;
      stb_q <= 1'b1;
      we_q  <= nxt_we;
      sel_q <= SEL_ALL;
      adr_q <= BASE_ADDR | 32'(idx_d);
      dat_q <= nxt_data;
    end else if (drop) begin
      cyc_q <= 1'b0;
      stb_q <= 1'b0;
      we_q  <= 1'b0;
      sel_q <= 4'h0;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = ok_q;
  assign fail_o      = fail_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_data_o = fail_data_q;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = stb_q;
  assign wbm_we_o    = we_q;
  assign wbm_sel_o   = sel_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;

endmodule
